// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin scheduler in front of the 4:1 two-bit lane mux.
// Holds the channel codes, the scheduler state enum and the {s0,s1} select encoding,
// which the mux bench reuses.
package mux_rr_scheduler_pkg;

   localparam logic [1:0] CH_A = 2'b00;
   localparam logic [1:0] CH_B = 2'b01;
   localparam logic [1:0] CH_C = 2'b10;
   localparam logic [1:0] CH_D = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SEL,
      OUT
   } state_e;

   // Mux select pair; s0 is the MSB, so {s0,s1} carries the channel code directly.
   typedef struct packed {
      logic s0;
      logic s1;
   } sel_t;

   function automatic sel_t ch_to_sel(logic [1:0] ch);
      return sel_t'(ch);
   endfunction

   function automatic logic [3:0] ch_onehot(logic [1:0] ch);
      return 4'b0001 << ch;
   endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Bus between the scheduler and its surroundings (requesters, mux, downstream sink).
//   req       requester lines, bit0=a .. bit3=d
//   s0/s1     registered mux select, {s0,s1} = channel code
//   y_in      mux output fed back for capture
//   out_*     registered valid/ready beat with channel tag
//   ack       one-hot acceptance pulse to the served requester
// master = scheduler side, slave = environment side.
interface mux_rr_scheduler_if #(
   parameter int unsigned DW = 2
) ();

   logic [3:0]    req;
   logic          s0;
   logic          s1;
   logic [DW-1:0] y_in;
   logic [DW-1:0] out_data;
   logic [1:0]    out_ch;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    ack;

   modport master (
      input  req, y_in, out_ready,
      output s0, s1, out_data, out_ch, out_valid, ack
   );

   modport slave (
      output req, y_in, out_ready,
      input  s0, s1, out_data, out_ch, out_valid, ack
   );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick4.sv
// Combinational round-robin picker for four requesters.
//   req        request vector
//   last       index granted most recently
//   grant_idx  first asserted request searching upward from last+1 (mod 4)
//   any        at least one request is asserted
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] grant_idx,
   output logic       any
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      grant_idx = last + 2'd1;
      found     = 1'b0;
      idx       = '0;
      // Offsets 1..4 so the last-granted channel is the lowest priority.
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!found && req[idx]) begin
            grant_idx = idx;
            found     = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the select of a 4:1 lane mux and forwarding each selected
// beat on a registered valid/ready output with a channel tag.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     master side of mux_rr_scheduler_if (req, s0/s1, y_in, out_*, ack)
// Parameters: DW lane width (match the mux), BURST max consecutive beats per channel (>=1).
module mux_rr_scheduler
   import mux_rr_scheduler_pkg::*;
#(
   parameter int unsigned DW    = 2,
   parameter int unsigned BURST = 2
) (
   input logic              clk,
   input logic              rst_n,
   mux_rr_scheduler_if.master bus
);

   localparam int unsigned    BW     = $clog2(BURST + 1);
   localparam logic [BW-1:0] BurstW = BW'(BURST);

   state_e        state_q, state_d;
   sel_t          sel_q, sel_d;
   logic [1:0]    cur_q, cur_d;
   logic [1:0]    last_q, last_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [1:0]    out_ch_q, out_ch_d;
   logic          out_valid_q, out_valid_d;
   logic [3:0]    ack_q, ack_d;

   logic [1:0]    grant_idx;
   logic          any_req;
   logic [BW-1:0] bcnt_inc;
   logic          accept;
   logic          burst_more;

   rr_pick4 u_pick (
      .req       (bus.req),
      .last      (last_q),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   assign bcnt_inc   = bcnt_q + 1'b1;
   assign accept     = out_valid_q && bus.out_ready;
   // Burst continues only while the served channel still requests and has budget left.
   assign burst_more = bus.req[cur_q] && (bcnt_inc < BurstW);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         cur_q       <= CH_A;
         last_q      <= CH_D;
         bcnt_q      <= '0;
         out_data_q  <= '0;
         out_ch_q    <= CH_A;
         out_valid_q <= 1'b0;
         ack_q       <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         bcnt_q      <= bcnt_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ack_q       <= ack_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_req) state_d = SEL;
         SEL:     state_d = OUT;
         OUT:     if (accept) state_d = burst_more ? SEL : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered-output and datapath next values
   always_comb begin
      sel_d       = sel_q;
      cur_d       = cur_q;
      last_d      = last_q;
      bcnt_d      = bcnt_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ack_d       = '0;
      unique case (state_q)
         IDLE: begin
            // The grant is committed here; later request changes cannot cancel it.
            if (any_req) begin
               sel_d = ch_to_sel(grant_idx);
               cur_d = grant_idx;
            end
         end
         SEL: begin
            // Mux has had a full cycle to settle on sel_q.
            out_data_d  = bus.y_in;
            out_ch_d    = cur_q;
            out_valid_d = 1'b1;
         end
         OUT: begin
            if (accept) begin
               ack_d       = ch_onehot(cur_q);
               out_valid_d = 1'b0;
               if (burst_more) begin
                  bcnt_d = bcnt_inc;
               end else begin
                  last_d = cur_q;
                  bcnt_d = '0;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.s0        = sel_q.s0;
   assign bus.s1        = sel_q.s1;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ack       = ack_q;

endmodule
